// File: rtl/rdma_remap_arb.sv
// Round-robin front end that shares one rdma_remap engine among NREQ requesters.
// One translation in flight at a time; engine timeouts return an error response.
module rdma_remap_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*32-1:0]      req_addr,
  output logic [NREQ-1:0]         req_ready,
  output logic                    eng_start,
  output logic [31:0]             eng_local_addr,
  input  logic [31:0]             eng_remote_addr,
  input  logic                    eng_ready,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [31:0]             rsp_addr,
  output logic                    rsp_err,
  input  logic                    rsp_ready
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q;
  logic [IW-1:0] last_grant_q;
  logic [CW-1:0] cnt_q;
  logic          eng_start_q;
  logic [31:0]   laddr_q;
  logic          rsp_valid_q;
  logic [IW-1:0] rsp_id_q;
  logic [31:0]   rsp_addr_q;
  logic          rsp_err_q;

  logic [31:0]   addr_arr [NREQ];
  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  logic [31:0]   gnt_addr;

  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[32*g +: 32];
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    logic [IW-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_addr  = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(last_grant_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
        gnt_addr  = addr_arr[cand];
      end
    end
  end

  // The accept strobe must answer in the grant cycle, so it is combinational.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && gnt_found) begin
      req_ready = NREQ'(1) << gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= IW'(NREQ - 1);
      cnt_q        <= '0;
      eng_start_q  <= 1'b0;
      laddr_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_addr_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            state_q      <= S_ISSUE;
            last_grant_q <= gnt_idx;
            rsp_id_q     <= gnt_idx;
            laddr_q      <= gnt_addr;
            eng_start_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          if (eng_ready) begin
            rsp_addr_q  <= eng_remote_addr;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_start      = eng_start_q;
  assign eng_local_addr = laddr_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_addr       = rsp_addr_q;
  assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_rdma_remap_arb.sv
// Randomized bench for rdma_remap_arb against a transaction-timeline reference model.
module tb_rdma_remap_arb;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned IW      = $clog2(NREQ);
  localparam logic [31:0] MSB     = 32'h8000_0000;

  localparam int M_SINGLE = 0;
  localparam int M_FAIR   = 1;
  localparam int M_BP     = 2;
  localparam int M_TMO    = 3;
  localparam int M_RAND   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic              eng_start;
  logic [31:0]       eng_local_addr;
  logic [31:0]       eng_remote_addr;
  logic              eng_ready;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [31:0]       rsp_addr;
  logic              rsp_err;
  logic              rsp_ready;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: one transaction described by its start cycle and response cycle.
  bit          busy;
  int          t;
  int          start_c;
  int          resp_c;
  int          lat;
  int unsigned lg;
  int unsigned m_id;
  logic [31:0] m_laddr;
  logic [31:0] m_raddr;
  bit          m_err;
  int          bp_left;
  logic [31:0] addr_tab [NREQ];

  always #5 clk = ~clk;

  rdma_remap_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .eng_start       (eng_start),
    .eng_local_addr  (eng_local_addr),
    .eng_remote_addr (eng_remote_addr),
    .eng_ready       (eng_ready),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_addr        (rsp_addr),
    .rsp_err         (rsp_err),
    .rsp_ready       (rsp_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, t, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int unsigned last);
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned c;
      c = (last + k) % NREQ;
      if (v[c]) return int'(c);
    end
    return -1;
  endfunction

  function automatic int choose_lat(input int md);
    int r;
    case (md)
      M_SINGLE, M_FAIR: return 1;
      M_BP:             return int'($urandom_range(1, 4));
      M_TMO:            return int'(TIMEOUT) + 1 + int'($urandom_range(0, 3));
      default: begin
        r = int'($urandom_range(0, 9));
        if (r < 6)       return int'($urandom_range(1, 6));
        else if (r == 6) return int'(TIMEOUT);
        else if (r == 7) return int'(TIMEOUT) - 1;
        else if (r == 8) return int'(TIMEOUT) + 1;
        else             return int'(TIMEOUT) + 5;
      end
    endcase
  endfunction

  task automatic drive_addrs();
    for (int unsigned i = 0; i < NREQ; i++) req_addr[32*i +: 32] = addr_tab[i];
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    t++;
    rst_n           = 1'b0;
    req_valid       = NREQ'($urandom);
    rsp_ready       = 1'($urandom);
    eng_ready       = 1'($urandom);
    eng_remote_addr = $urandom;
    busy            = 1'b0;
    lg              = NREQ - 1;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("rst_eng_start", 32'(eng_start), 32'h0);
    check_eq("rst_eng_local_addr", eng_local_addr, 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'h0);
    check_eq("rst_rsp_addr", rsp_addr, 32'h0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'h0);
  endtask

  task automatic step(input int md);
    logic [NREQ-1:0] v;
    int p;
    bit in_wait;
    p = -1;
    @(posedge clk);
    #1;
    t++;
    rst_n   = 1'b1;
    in_wait = busy && (t > start_c) && (t < resp_c);

    case (md)
      M_SINGLE: begin
        v = busy ? '0 : NREQ'(1);
        addr_tab[0] = 32'h0000_1000;
      end
      M_FAIR: begin
        v = '1;
        addr_tab[0] = 32'hFFFF_0000;
        addr_tab[1] = 32'h0000_0000;
        addr_tab[2] = 32'h7FFF_FFFF;
        addr_tab[3] = 32'h0000_1000;
      end
      default: begin
        v = NREQ'($urandom);
        for (int unsigned i = 0; i < NREQ; i++) addr_tab[i] = $urandom;
      end
    endcase
    req_valid = v;
    drive_addrs();

    if (busy && t >= resp_c) begin
      rsp_ready = (bp_left == 0) ? ((md == M_RAND) ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0;
      if (bp_left > 0) bp_left--;
    end else begin
      rsp_ready = 1'($urandom);
    end

    if (in_wait) begin
      eng_ready       = (lat <= int'(TIMEOUT)) && (t == start_c + lat);
      eng_remote_addr = eng_ready ? (m_laddr ^ MSB) : $urandom;
    end else begin
      eng_ready       = ($urandom_range(0, 3) == 0);
      eng_remote_addr = $urandom;
    end

    @(negedge clk);
    if (!busy) begin
      p = pick(v, lg);
      check_eq("req_ready", 32'(req_ready), (p < 0) ? 32'h0 : (32'h1 << p));
      check_eq("eng_start_idle", 32'(eng_start), 32'h0);
      check_eq("rsp_valid_idle", 32'(rsp_valid), 32'h0);
    end else begin
      check_eq("req_ready_busy", 32'(req_ready), 32'h0);
      check_eq("eng_start", 32'(eng_start), 32'(t == start_c));
      if (t < resp_c) check_eq("eng_local_addr", eng_local_addr, m_laddr);
      check_eq("rsp_valid", 32'(rsp_valid), 32'(t >= resp_c));
      if (t >= resp_c) begin
        check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
        check_eq("rsp_addr", rsp_addr, m_raddr);
        check_eq("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end

    if (!busy) begin
      if (p >= 0) begin
        busy    = 1'b1;
        lg      = p;
        m_id    = p;
        m_laddr = addr_tab[p];
        start_c = t + 1;
        lat     = choose_lat(md);
        bp_left = (md == M_BP) ? 5 : 0;
        if (lat <= int'(TIMEOUT)) begin
          resp_c  = start_c + lat + 1;
          m_raddr = m_laddr ^ MSB;
          m_err   = 1'b0;
        end else begin
          resp_c  = start_c + int'(TIMEOUT) + 1;
          m_raddr = 32'h0;
          m_err   = 1'b1;
        end
      end
    end else if (t >= resp_c && rsp_ready) begin
      busy = 1'b0;
    end
  endtask

  initial begin
    bit hit;
    rst_n           = 1'b0;
    req_valid       = '0;
    req_addr        = '0;
    rsp_ready       = 1'b0;
    eng_ready       = 1'b0;
    eng_remote_addr = '0;
    t               = 0;
    busy            = 1'b0;
    lg              = NREQ - 1;
    bp_left         = 0;
    for (int unsigned i = 0; i < NREQ; i++) addr_tab[i] = '0;

    reset_cycle();
    reset_cycle();
    for (int i = 0; i < 12; i++) step(M_SINGLE);

    reset_cycle();
    for (int i = 0; i < 24; i++) step(M_FAIR);

    for (int i = 0; i < 80; i++) step(M_BP);
    for (int i = 0; i < 80; i++) step(M_TMO);

    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step(M_TMO);
      if (busy && t == start_c + 3) hit = 1'b1;
    end
    check_eq("reach_mid_wait", 32'(hit), 32'h1);
    reset_cycle();
    for (int i = 0; i < 12; i++) step(M_FAIR);

    for (int i = 0; i < 3000; i++) step(M_RAND);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
